complex_accumulator: RTL

- Integrate-and-dump stage directly downstream of complex_multiplier; consumes its m_axis_dout stream of complex products.
- Sums N consecutive complex samples, scales the sum by a right shift, saturates it and emits one complex result per block.
- Intended for correlator/despreader chains (multiply by reference, then integrate).
- AXI-Stream on both sides with full backpressure support.

---
 rtl/complex_accumulator.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/complex_accumulator.sv
// Integrate-and-dump for a complex sample stream: sums N samples, shifts,
// saturates and emits one complex result per block over AXI-Stream.
module complex_accumulator #(
    parameter int INPUT_WIDTH   = 32,
    parameter int OUTPUT_WIDTH  = 32,
    parameter int ACC_LEN_WIDTH = 16,
    parameter int SHIFT_WIDTH   = 6,
    parameter int BYTE_ALIGNED  = 1,
    localparam int EFF_IN  = (BYTE_ALIGNED != 0) ? ((2*INPUT_WIDTH+15)/16)*16  : 2*INPUT_WIDTH,
    localparam int EFF_OUT = (BYTE_ALIGNED != 0) ? ((2*OUTPUT_WIDTH+15)/16)*16 : 2*OUTPUT_WIDTH
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [ACC_LEN_WIDTH-1:0] cfg_acc_len,
    input  logic [SHIFT_WIDTH-1:0]   cfg_shift,
    input  logic [EFF_IN-1:0]        s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tuser,
    output logic [EFF_OUT-1:0]       m_axis_dout_tdata,
    output logic                     m_axis_dout_tvalid,
    input  logic                     m_axis_dout_tready,
    output logic                     m_axis_dout_tuser
);

    localparam int ACC_W    = INPUT_WIDTH + ACC_LEN_WIDTH;
    localparam int HALF_IN  = EFF_IN / 2;
    localparam int HALF_OUT = EFF_OUT / 2;
    // One guard bit above the wider of accumulator/output keeps the saturation compare exact.
    localparam int EXT_W    = ((ACC_W > OUTPUT_WIDTH) ? ACC_W : OUTPUT_WIDTH) + 1;

    logic [ACC_LEN_WIDTH-1:0] count_reg;
    logic [ACC_LEN_WIDTH-1:0] len_reg;
    logic [SHIFT_WIDTH-1:0]   shift_reg;
    logic [SHIFT_WIDTH-1:0]   dump_shift_reg;
    logic                     dump_valid_reg;
    logic [EFF_OUT-1:0]       out_data_reg;
    logic                     out_valid_reg;
    logic                     out_user_reg;

    logic                     accept;
    logic                     block_start;
    logic                     dump_now;
    logic                     load_out;
    logic [ACC_LEN_WIDTH-1:0] len_eff;
    logic [ACC_LEN_WIDTH-1:0] count_next;
    logic [SHIFT_WIDTH-1:0]   shift_clamped;
    logic [SHIFT_WIDTH-1:0]   shift_eff;
    logic [EFF_OUT-1:0]       out_word;
    logic [1:0]               clip_vec;

    assign s_axis_tready = !(dump_valid_reg && out_valid_reg && !m_axis_dout_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    // An empty count means the previous block was dumped (or reset), so this sample opens a new one.
    assign block_start   = (count_reg == '0) || s_axis_tuser;

    always_comb begin
        shift_clamped = cfg_shift;
        if (32'(cfg_shift) > ACC_W - 1)
            shift_clamped = SHIFT_WIDTH'(ACC_W - 1);
    end

    assign len_eff    = block_start ? ((cfg_acc_len == '0) ? ACC_LEN_WIDTH'(1) : cfg_acc_len) : len_reg;
    assign shift_eff  = block_start ? shift_clamped : shift_reg;
    assign count_next = block_start ? ACC_LEN_WIDTH'(1) : count_reg + ACC_LEN_WIDTH'(1);
    assign dump_now   = accept && (count_next == len_eff);
    assign load_out   = dump_valid_reg && (!out_valid_reg || m_axis_dout_tready);

    // Lane 0 is the real component, lane 1 the imaginary component.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            localparam logic signed [EXT_W-1:0] SAT_MAX =
                {{(EXT_W-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
            localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

            logic signed [ACC_W-1:0]        acc_reg;
            logic signed [ACC_W-1:0]        dump_reg;
            logic signed [INPUT_WIDTH-1:0]  sample;
            logic signed [ACC_W-1:0]        sample_ext;
            logic signed [ACC_W-1:0]        sum_next;
            logic signed [EXT_W-1:0]        dump_wide;
            logic signed [EXT_W-1:0]        shifted;
            logic [OUTPUT_WIDTH-1:0]        sat;
            logic                           clip;
            logic [HALF_OUT-1:0]            out_lane;

            assign sample     = s_axis_tdata[gi*HALF_IN +: INPUT_WIDTH];
            assign sample_ext = {{ACC_LEN_WIDTH{sample[INPUT_WIDTH-1]}}, sample};
            assign sum_next   = block_start ? sample_ext : acc_reg + sample_ext;
            assign dump_wide  = {{(EXT_W-ACC_W){dump_reg[ACC_W-1]}}, dump_reg};
            assign shifted    = dump_wide >>> dump_shift_reg;

            always_comb begin
                clip = 1'b0;
                sat  = shifted[OUTPUT_WIDTH-1:0];
                if (shifted > SAT_MAX) begin
                    sat  = SAT_MAX[OUTPUT_WIDTH-1:0];
                    clip = 1'b1;
                end else if (shifted < SAT_MIN) begin
                    sat  = SAT_MIN[OUTPUT_WIDTH-1:0];
                    clip = 1'b1;
                end
            end

            if (HALF_OUT > OUTPUT_WIDTH) begin : g_pad
                assign out_lane = {{(HALF_OUT-OUTPUT_WIDTH){sat[OUTPUT_WIDTH-1]}}, sat};
            end else begin : g_nopad
                assign out_lane = sat;
            end

            assign out_word[gi*HALF_OUT +: HALF_OUT] = out_lane;
            assign clip_vec[gi] = clip;

            always_ff @(posedge aclk) begin
                if (areset) begin
                    acc_reg  <= '0;
                    dump_reg <= '0;
                end else begin
                    if (accept)
                        acc_reg <= dump_now ? '0 : sum_next;
                    if (dump_now)
                        dump_reg <= sum_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (areset) begin
            count_reg      <= '0;
            len_reg        <= '0;
            shift_reg      <= '0;
            dump_shift_reg <= '0;
            dump_valid_reg <= 1'b0;
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            out_user_reg   <= 1'b0;
        end else begin
            if (accept) begin
                count_reg <= dump_now ? '0 : count_next;
                if (block_start) begin
                    len_reg   <= len_eff;
                    shift_reg <= shift_eff;
                end
            end
            // The shift travels with the dumped sum, since the next block may latch a new one.
            if (dump_now) begin
                dump_valid_reg <= 1'b1;
                dump_shift_reg <= shift_eff;
            end else if (load_out) begin
                dump_valid_reg <= 1'b0;
            end

            if (load_out) begin
                out_data_reg  <= out_word;
                out_user_reg  <= |clip_vec;
                out_valid_reg <= 1'b1;
            end else if (m_axis_dout_tready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign m_axis_dout_tdata  = out_data_reg;
    assign m_axis_dout_tvalid = out_valid_reg;
    assign m_axis_dout_tuser  = out_user_reg;

endmodule
